// File: rtl/shiftreg_ser_ctrl.sv
// shiftreg_ser_ctrl: upstream controller for a 4-mode shift register
// (00 hold, 01 shift left, 10 shift right, 11 load). It accepts parallel
// words on a valid/ready input and steers the register's mode/load/fill
// inputs. It reads the register back so that one bit per beat leaves on a
// valid/ready serial stream. Back-to-back words are sent with no idle beat.
module shiftreg_ser_ctrl #(
  parameter int DATASIZE  = 8,    // word width, must be >= 2
  parameter bit LSB_FIRST = 1'b0, // 0: MSB first via shift left, 1: LSB first via shift right
  parameter bit FILL_BIT  = 1'b0  // constant shifted into the vacated end
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATASIZE-1:0] data_i,
  input  logic                data_valid_i,
  output logic                data_ready_o,
  output logic [1:0]          mode_o,
  output logic [DATASIZE-1:0] load_value_o,
  output logic                ser_in_msb_o,
  output logic                ser_in_lsb_o,
  input  logic [DATASIZE-1:0] value_i,
  output logic                ser_o,
  output logic                ser_valid_o,
  input  logic                ser_ready_i,
  output logic                ser_last_o,
  output logic                busy_o
);

  localparam int CW = $clog2(DATASIZE);

  localparam logic [1:0]    MODE_HOLD  = 2'b00;
  localparam logic [1:0]    MODE_LOAD  = 2'b11;
  localparam logic [1:0]    MODE_SHIFT = LSB_FIRST ? 2'b10 : 2'b01;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DATASIZE - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_last;

  // The register itself holds the word; this block only passes data through
  // and picks the bit that leaves the word first.
  assign load_value_o = data_i;
  assign ser_in_msb_o = FILL_BIT;
  assign ser_in_lsb_o = FILL_BIT;
  assign ser_o        = LSB_FIRST ? value_i[0] : value_i[DATASIZE-1];

  // Only the exit bit of the read-back word matters; the rest is read on purpose.
  logic w_unused_value;
  assign w_unused_value = ^value_i;

  assign w_last = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);

  // State and bit counter; everything else is decoded from them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, so the order of these lines cannot change behaviour.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, counter and all handshake/mode outputs.
  always_comb begin
    // NOTE: each output gets a default before any branch so that no path
    // leaves a signal unassigned; an unassigned path would infer a latch.
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    mode_o       = MODE_HOLD;
    data_ready_o = 1'b0;
    ser_valid_o  = 1'b0;
    ser_last_o   = 1'b0;
    busy_o       = 1'b0;

    // While reset is asserted, all outputs stay at their defaults. This keeps
    // them quiet even before the flops have settled.
    if (!rst_i) begin
      case (r_state)
        ST_IDLE: begin
          data_ready_o = 1'b1;
          if (data_valid_i) begin
            mode_o      = MODE_LOAD;
            w_state_nxt = ST_SHIFT;
            w_cnt_nxt   = '0;
          end
        end

        ST_SHIFT: begin
          ser_valid_o  = 1'b1;
          busy_o       = 1'b1;
          ser_last_o   = w_last;
          // A new word can only enter when the last bit of this word leaves.
          data_ready_o = w_last & ser_ready_i;
          if (ser_ready_i) begin
            if (!w_last) begin
              mode_o    = MODE_SHIFT;
              w_cnt_nxt = r_cnt + 1'b1;
            end else begin
              w_cnt_nxt = '0;
              if (data_valid_i) begin
                // A load on the last beat replaces the shift, so there is no bubble.
                mode_o = MODE_LOAD;
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end
          end
        end

        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftreg_ser_ctrl.sv
// Bench for shiftreg_ser_ctrl. The bench builds two controllers, one MSB-first
// and one LSB-first. Each one drives its own behavioural 4-mode shift register.
// Both share the same input stimulus. A word-level model predicts the outputs
// on every cycle: which word is in flight and how many of its bits remain.
// Directed scenarios then pin that model to hand-computed values.
module tb_shiftreg_ser_ctrl;

  localparam int DS = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DS-1:0] data_i = '0;
  logic          data_valid_i = 1'b0;
  logic          ser_ready_i = 1'b0;

  // MSB-first instance (suffix _m) and LSB-first instance (suffix _l).
  logic          rdy_m, rdy_l, ser_m, ser_l, vld_m, vld_l, last_m, last_l, busy_m, busy_l;
  logic          fmsb_m, flsb_m, fmsb_l, flsb_l;
  logic [1:0]    mode_m, mode_l;
  logic [DS-1:0] ldv_m, ldv_l, reg_m, reg_l;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shiftreg_ser_ctrl #(.DATASIZE(DS), .LSB_FIRST(1'b0), .FILL_BIT(1'b0)) dut_m (
    .clk_i(clk), .rst_i(rst), .data_i(data_i), .data_valid_i(data_valid_i),
    .data_ready_o(rdy_m), .mode_o(mode_m), .load_value_o(ldv_m),
    .ser_in_msb_o(fmsb_m), .ser_in_lsb_o(flsb_m), .value_i(reg_m),
    .ser_o(ser_m), .ser_valid_o(vld_m), .ser_ready_i(ser_ready_i),
    .ser_last_o(last_m), .busy_o(busy_m)
  );

  shiftreg_ser_ctrl #(.DATASIZE(DS), .LSB_FIRST(1'b1), .FILL_BIT(1'b0)) dut_l (
    .clk_i(clk), .rst_i(rst), .data_i(data_i), .data_valid_i(data_valid_i),
    .data_ready_o(rdy_l), .mode_o(mode_l), .load_value_o(ldv_l),
    .ser_in_msb_o(fmsb_l), .ser_in_lsb_o(flsb_l), .value_i(reg_l),
    .ser_o(ser_l), .ser_valid_o(vld_l), .ser_ready_i(ser_ready_i),
    .ser_last_o(last_l), .busy_o(busy_l)
  );

  // Behavioural 4-mode shift registers driven by the controllers.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_m <= '0;
      reg_l <= '0;
    end else begin
      case (mode_m)
        2'b01:   reg_m <= {reg_m[DS-2:0], flsb_m};
        2'b10:   reg_m <= {fmsb_m, reg_m[DS-1:1]};
        2'b11:   reg_m <= ldv_m;
        default: reg_m <= reg_m;
      endcase
      case (mode_l)
        2'b01:   reg_l <= {reg_l[DS-2:0], flsb_l};
        2'b10:   reg_l <= {fmsb_l, reg_l[DS-1:1]};
        2'b11:   reg_l <= ldv_l;
        default: reg_l <= reg_l;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model state: the word in flight and the number of its bits still to send.
  logic [DS-1:0] cur_word = '0;
  int            left = 0;
  bit            accepted = 1'b0;
  // Words rebuilt from each serial stream, plus the longest streak of transfers.
  logic [DS-1:0] rx_m = '0, rx_l = '0;
  logic [DS-1:0] rxq_m[$], rxq_l[$];
  int            run_len = 0, max_run = 0;

  // Compare process: the inputs are stable at the falling edge, so this
  // process checks the outputs there. It then advances the model by the
  // handshakes that the next rising edge will carry out.
  always @(negedge clk) begin
    bit         e_vld, e_last, e_rdy;
    logic [1:0] e_mode_m, e_mode_l;
    int         k;
    if (rst) begin
      check("rst_ready_m", rdy_m, 0);  check("rst_ready_l", rdy_l, 0);
      check("rst_valid_m", vld_m, 0);  check("rst_valid_l", vld_l, 0);
      check("rst_last_m",  last_m, 0); check("rst_last_l",  last_l, 0);
      check("rst_busy_m",  busy_m, 0); check("rst_busy_l",  busy_l, 0);
      check("rst_mode_m",  mode_m, 0); check("rst_mode_l",  mode_l, 0);
      left = 0;
      run_len = 0;
    end else begin
      e_vld  = (left > 0);
      e_last = (left == 1);
      e_rdy  = !e_vld || (e_last && ser_ready_i);
      if (!e_vld)            begin e_mode_m = data_valid_i ? 2'b11 : 2'b00; e_mode_l = e_mode_m; end
      else if (!ser_ready_i) begin e_mode_m = 2'b00; e_mode_l = 2'b00; end
      else if (!e_last)      begin e_mode_m = 2'b01; e_mode_l = 2'b10; end
      else                   begin e_mode_m = data_valid_i ? 2'b11 : 2'b00; e_mode_l = e_mode_m; end

      check("valid_m", vld_m, e_vld);   check("valid_l", vld_l, e_vld);
      check("last_m", last_m, e_last);  check("last_l", last_l, e_last);
      check("busy_m", busy_m, e_vld);   check("busy_l", busy_l, e_vld);
      check("ready_m", rdy_m, e_rdy);   check("ready_l", rdy_l, e_rdy);
      check("mode_m", mode_m, e_mode_m); check("mode_l", mode_l, e_mode_l);
      check("loadval_m", ldv_m, data_i); check("loadval_l", ldv_l, data_i);
      check("fill_m", {fmsb_m, flsb_m}, 0); check("fill_l", {fmsb_l, flsb_l}, 0);
      if (e_vld) begin
        k = DS - left;
        check("ser_m", ser_m, cur_word[DS-1-k]);
        check("ser_l", ser_l, cur_word[k]);
      end

      if (e_vld && ser_ready_i) begin
        rx_m = {rx_m[DS-2:0], ser_m};
        rx_l = {ser_l, rx_l[DS-1:1]};
        if (e_last) begin
          rxq_m.push_back(rx_m);
          rxq_l.push_back(rx_l);
        end
        left--;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (data_valid_i && e_rdy) begin
        cur_word = data_i;
        left     = DS;
        accepted = 1'b1;
      end
    end
  end

  // Offer one word and hold it until it is accepted. If keep_valid is set,
  // data_valid_i is left high afterwards.
  task automatic push_word(input logic [DS-1:0] w, input bit keep_valid);
    int n = 0;
    @(posedge clk); #1;
    data_i = w;
    data_valid_i = 1'b1;
    accepted = 1'b0;
    while (!accepted && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", accepted, 1);
    @(posedge clk); #1;
    if (!keep_valid) data_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_m || left != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy_m, 0);
  endtask

  task automatic expect_rx(input string name, input logic [DS-1:0] w);
    check({name, "_count"}, rxq_m.size() + rxq_l.size(), 2);
    if (rxq_m.size() > 0) check({name, "_msb_first"}, rxq_m.pop_front(), w);
    if (rxq_l.size() > 0) check({name, "_lsb_first"}, rxq_l.pop_front(), w);
    rxq_m.delete();
    rxq_l.delete();
  endtask

  task automatic wait_bits_left(input int target);
    int n = 0;
    while (left != target && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("bits_left_timeout", left, target);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", rdy_m, 0);
    check("reset_valid", vld_m, 0);
    rst = 1'b0;
    ser_ready_i = 1'b1;
    @(negedge clk);
    check("idle_ready", rdy_m, 1);
    check("idle_mode", mode_m, 0);

    // 0xA5 emitted MSB first: 1,0,1,0,0,1,0,1 and rebuilt by both instances.
    push_word(8'hA5, 1'b0);
    wait_idle();
    expect_rx("a5", 8'hA5);

    // 0x01 on the LSB-first instance: mode 11, then 10 x7, then 00; bits 1 then 0 x7.
    @(posedge clk); #1;
    data_i = 8'h01;
    data_valid_i = 1'b1;
    @(negedge clk);
    check("lsb_load_ready", rdy_l, 1);
    check("lsb_load_mode", mode_l, 2'b11);
    @(posedge clk); #1;
    data_valid_i = 1'b0;
    for (int i = 0; i < DS; i++) begin
      @(negedge clk);
      check("lsb_seq_mode", mode_l, (i < DS - 1) ? 2'b10 : 2'b00);
      check("lsb_seq_bit", ser_l, (i == 0) ? 1 : 0);
    end
    wait_idle();
    expect_rx("x01", 8'h01);

    // 0xF0 with three stalled beats at bit 4: held mode and bit, nothing lost.
    push_word(8'hF0, 1'b0);
    wait_bits_left(DS - 4);
    ser_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_mode", mode_m, 2'b00);
      check("stall_bit", ser_m, 0);
      check("stall_valid", vld_m, 1);
    end
    @(posedge clk); #1;
    ser_ready_i = 1'b1;
    wait_idle();
    expect_rx("f0", 8'hF0);

    // Back-to-back 0x3C, 0xC3: 16 consecutive transfers with no bubble.
    max_run = 0;
    push_word(8'h3C, 1'b1);
    push_word(8'hC3, 1'b0);
    wait_idle();
    check("b2b_run", max_run, 2 * DS);
    check("b2b_count", rxq_m.size(), 2);
    if (rxq_m.size() > 0) check("b2b_first", rxq_m.pop_front(), 8'h3C);
    if (rxq_l.size() > 0) check("b2b_first_l", rxq_l.pop_front(), 8'h3C);
    if (rxq_m.size() > 0) check("b2b_second", rxq_m.pop_front(), 8'hC3);
    if (rxq_l.size() > 0) check("b2b_second_l", rxq_l.pop_front(), 8'hC3);
    rxq_m.delete();
    rxq_l.delete();

    // Asynchronous reset at bit 3: outputs clear at once, the partial word is dropped.
    push_word(8'h55, 1'b0);
    wait_bits_left(DS - 3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", vld_m | vld_l, 0);
    check("async_rst_ready", rdy_m | rdy_l, 0);
    check("async_rst_busy", busy_m | busy_l, 0);
    check("async_rst_mode", {mode_m, mode_l}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_dropped_word", rxq_m.size() + rxq_l.size(), 0);
    push_word(8'h81, 1'b0);
    wait_idle();
    expect_rx("x81", 8'h81);

    // Random valid/ready stalls; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      ser_ready_i = ($urandom_range(3) != 0);
      if (!data_valid_i || accepted) begin
        accepted = 1'b0;
        data_valid_i = ($urandom_range(2) != 0);
        data_i = DS'($urandom);
      end
    end
    @(posedge clk); #1;
    data_valid_i = 1'b0;
    ser_ready_i = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
